// File: rtl/shift_unit_seq_if.sv
// Handshake bundle for the sequential shifter.
// Producer/consumer side is master, shifter side is slave.
interface shift_unit_seq_if #(
  parameter int N  = 16,
  parameter int SW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  data;
  logic [SW-1:0] shift;
  logic [2:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  resultado;
  logic          carry;
  logic          zero;
  logic          err;

  modport master (
    output in_valid, data, shift, mode, out_ready,
    input  in_ready, out_valid, resultado, carry, zero, err
  );

  modport slave (
    input  in_valid, data, shift, mode, out_ready,
    output in_ready, out_valid, resultado, carry, zero, err
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Sequential shifter: LSL/LSR/ASR/ROL/ROR, one bit per clock.
// Valid/ready on both sides, carry/zero/err flags.
module shift_unit_seq #(
  parameter int N  = 16,
  parameter int SW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  shift_unit_seq_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [SW-1:0] NS = SW'(N);
  localparam logic [CW-1:0] NC = CW'(N);

  localparam logic [2:0] M_LSL = 3'd0;
  localparam logic [2:0] M_LSR = 3'd1;
  localparam logic [2:0] M_ASR = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]  work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    mode_q, mode_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;
  logic [CW-1:0] eff;
  logic          bad_mode;

  assign bad_mode = (bus.mode > M_ROR);

  // Effective step count: linear shifts saturate at N, rotates wrap.
  always_comb begin
    eff = '0;
    unique case (1'b1)
      (bus.mode <= M_ASR):
        eff = (bus.shift >= NS) ? NC : CW'(bus.shift);
      (bus.mode == M_ROL || bus.mode == M_ROR):
        eff = CW'(bus.shift % NS);
      default:
        eff = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clr always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:
          if (bus.in_valid)
            state_d = (eff == '0) ? DONE : SHIFT;
        SHIFT:
          if (cnt_q == CW'(1)) state_d = DONE;
        DONE:
          if (bus.out_ready) state_d = IDLE;
        default:
          state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded purely from state.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // Datapath next state: capture, single-bit step, hold.
  always_comb begin
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    err_d   = err_q;
    if (clr) begin
      work_d  = '0;
      cnt_d   = '0;
      carry_d = 1'b0;
      zero_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_d  = bus.data;
            mode_d  = bus.mode;
            cnt_d   = eff;
            carry_d = 1'b0;
            zero_d  = (bus.data == '0);
            err_d   = bad_mode;
          end
        end
        SHIFT: begin
          unique case (mode_q)
            M_LSL: begin
              work_d  = {work_q[N-2:0], 1'b0};
              carry_d = work_q[N-1];
            end
            M_LSR: begin
              work_d  = {1'b0, work_q[N-1:1]};
              carry_d = work_q[0];
            end
            M_ASR: begin
              work_d  = {work_q[N-1], work_q[N-1:1]};
              carry_d = work_q[0];
            end
            M_ROL: begin
              work_d  = {work_q[N-2:0], work_q[N-1]};
              carry_d = work_q[N-1];
            end
            M_ROR: begin
              work_d  = {work_q[0], work_q[N-1:1]};
              carry_d = work_q[0];
            end
            default: ;
          endcase
          cnt_d  = cnt_q - CW'(1);
          zero_d = (work_d == '0);
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.resultado = work_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq.
// Driver pushes model results; monitor pops on output handshake.
module tb_shift_unit_seq;

  localparam int N  = 16;
  localparam int SW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  shift_unit_seq_if #(.N(N), .SW(SW)) bus ();

  shift_unit_seq #(.N(N), .SW(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .bus  (bus)
  );

  typedef struct {
    logic [N-1:0] res;
    logic         cy;
    logic         zr;
    logic         er;
    int           lat;
    int           acc;
    int           hold;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion", nm);
  endtask

  // Reference: whole-operation arithmetic on a wide word.
  function automatic exp_t model(input logic [N-1:0] d,
                                 input int sh, input int md);
    exp_t e;
    logic [63:0] m;
    logic [63:0] dd;
    logic [63:0] r;
    logic signed [63:0] sd;
    int k;
    m  = (64'd1 << N) - 64'd1;
    dd = 64'(d);
    sd = $signed({{(64 - N){d[N-1]}}, d});
    if (md <= 2)      k = (sh < N) ? sh : N;
    else if (md <= 4) k = sh % N;
    else              k = 0;
    r    = dd;
    e.cy = 1'b0;
    if (k > 0) begin
      case (md)
        0: begin
          r    = (dd << k) & m;
          e.cy = dd[N-k];
        end
        1: begin
          r    = dd >> k;
          e.cy = dd[k-1];
        end
        2: begin
          r    = 64'(sd >>> k) & m;
          e.cy = sd[k-1];
        end
        3: begin
          r    = ((dd << k) | (dd >> (N - k))) & m;
          e.cy = r[0];
        end
        default: begin
          r    = ((dd >> k) | (dd << (N - k))) & m;
          e.cy = r[N-1];
        end
      endcase
    end
    e.res  = r[N-1:0];
    e.zr   = (r == 64'd0);
    e.er   = (md > 4);
    e.lat  = k;
    e.acc  = 0;
    e.hold = 0;
    return e;
  endfunction

  // Present one operand at a negedge where the block is idle.
  task automatic issue(input logic [N-1:0] d, input int sh,
                       input int md, input int hold, input bit push);
    exp_t e;
    int t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      timeout("issue_wait");
      return;
    end
    bus.in_valid = 1'b1;
    bus.data     = d;
    bus.shift    = SW'(sh);
    bus.mode     = 3'(md);
    if (push) begin
      e      = model(d, sh, md);
      e.acc  = cyc + 1;
      e.hold = hold;
      q.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data     = N'($urandom);
    bus.shift    = SW'($urandom);
    bus.mode     = 3'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !bus.in_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) timeout("drain");
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_in_ready"}, bus.in_ready, 1);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_res"}, bus.resultado, 0);
    chk({nm, "_flags"}, {bus.carry, bus.zero, bus.err}, 0);
  endtask

  // Monitor: latency, hold stability under backpressure, result.
  logic         act = 1'b0;
  logic         ho = 1'b0;
  int           wc = 0;
  logic [N-1:0] s_res;
  logic [2:0]   s_flg;

  always @(negedge clk) begin
    if (!rst_n) begin
      act = 1'b0;
      ho  = 1'b0;
      bus.out_ready = 1'b0;
    end else begin
      if (ho) begin
        chk("idle_after_hs", bus.in_ready, 1);
        chk("valid_drop", bus.out_valid, 0);
        ho = 1'b0;
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got 1 expected 0");
          bus.out_ready = 1'b1;
        end else begin
          if (!act) begin
            act   = 1'b1;
            wc    = 0;
            s_res = bus.resultado;
            s_flg = {bus.carry, bus.zero, bus.err};
            chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
          end else begin
            chk("hold_res", bus.resultado, s_res);
            chk("hold_flags", {bus.carry, bus.zero, bus.err}, s_flg);
          end
          chk("in_ready_low", bus.in_ready, 0);
          if (wc >= q[0].hold) begin
            chk("resultado", bus.resultado, q[0].res);
            chk("carry", bus.carry, q[0].cy);
            chk("zero", bus.zero, q[0].zr);
            chk("err", bus.err, q[0].er);
            void'(q.pop_front());
            act = 1'b0;
            ho  = 1'b1;
            bus.out_ready = 1'b1;
          end else begin
            wc++;
            bus.out_ready = 1'b0;
          end
        end
      end else begin
        bus.out_ready = 1'b0;
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.data     = '0;
    bus.shift    = '0;
    bus.mode     = '0;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_cleared("post_reset");

    issue(16'h0001, 4, 0, 0, 1);
    issue(16'h8000, 20, 2, 0, 1);
    issue(16'h8001, 16, 1, 0, 1);
    issue(16'h0001, 17, 4, 0, 1);
    issue(16'h1234, 16, 3, 0, 1);
    issue(16'hABCD, 5, 7, 0, 1);
    issue(16'h0003, 1, 0, 0, 1);
    issue(16'h00F0, 4, 1, 5, 1);
    issue(16'h8001, 0, 0, 0, 1);
    issue(16'h4000, 31, 2, 1, 1);

    for (int i = 0; i < 80; i++) begin
      issue(N'($urandom), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1);
    end
    drain();

    // clr together with in_valid in IDLE must not accept.
    bus.in_valid = 1'b1;
    bus.data     = 16'h5555;
    bus.shift    = SW'(0);
    bus.mode     = 3'd0;
    clr          = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    clr          = 1'b0;
    chk("clr_no_accept", bus.in_ready, 1);
    repeat (4) @(negedge clk);

    // clr two cycles into a shift.
    issue(16'h0001, 8, 0, 0, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk_cleared("clr");
    repeat (12) @(negedge clk);
    chk("clr_quiet", bus.out_valid, 0);

    // Asynchronous reset mid-shift.
    issue(16'h0001, 8, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_cleared("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_quiet", bus.out_valid, 0);

    issue(16'h0001, 4, 0, 0, 1);
    issue(16'h8000, 3, 4, 2, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
